// File: rtl/sd_frame_ctrl.sv
// Frame controller: accepts words over valid/ready, serialises them MSB-first,
// counts overlapping pattern matches per frame and pulses done at frame end.
module sd_frame_ctrl #(
  parameter int             DATA_W    = 8,
  parameter int             PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int             FRAME_LEN = 2,
  parameter int             CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              sd_din,
  output logic              sd_bit_valid,
  output logic              hit,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done,
  output logic              overflow
);

  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WORD_W = $clog2(FRAME_LEN + 1);
  localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shreg;
  logic [BIT_W-1:0]    bit_idx;
  logic [WORD_W-1:0]   word_cnt;
  logic [PAT_W-2:0]    hist;
  logic [FILL_W-1:0]   fill;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic [PAT_W-1:0]    window;
  logic                last_bit;
  logic                start_frame;
  logic [CNT_W:0]      cnt_inc;

  // Saturating increment: MSB of the result flags that the counter was already full.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, v};
    return {1'b0, v + 1'b1};
  endfunction

  assign last_bit    = (bit_idx == LAST_BIT);
  assign start_frame = (state == IDLE) && start;
  assign window      = {hist, sd_din};
  assign cnt_inc     = sat_inc(cnt);
  assign match_cnt   = cnt;
  assign overflow    = ovf;

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    sd_bit_valid = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT;
      end
      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        sd_bit_valid = 1'b1;
        if (last_bit) state_nxt = (word_cnt == LAST_WORD) ? DONE : WAIT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    sd_din = sd_bit_valid & shreg[DATA_W-1];
    // Fill qualification stops cleared history from matching patterns with leading zeros.
    hit    = sd_bit_valid && (window == PATTERN) && (fill == FILL_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx  <= '0;
      word_cnt <= '0;
      hist     <= '0;
      fill     <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else if (start_frame) begin
      bit_idx  <= '0;
      word_cnt <= '0;
      hist     <= '0;
      fill     <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      if (state == WAIT && in_valid) bit_idx <= '0;
      if (sd_bit_valid) begin
        bit_idx <= bit_idx + 1'b1;
        hist    <= window[PAT_W-2:0];
        if (last_bit)          word_cnt <= word_cnt + 1'b1;
        if (fill != FILL_MAX)  fill     <= fill + 1'b1;
        if (hit) begin
          cnt <= cnt_inc[CNT_W-1:0];
          ovf <= ovf | cnt_inc[CNT_W];
        end
      end
    end
  end

  // Word shift register is pure datapath; outputs are gated by sd_bit_valid.
  always_ff @(posedge clk) begin
    if (state == WAIT && in_valid) shreg <= in_data;
    else if (state == SHIFT)       shreg <= shreg << 1;
  end

endmodule

// File: tb/tb_sd_frame_ctrl.sv
// Directed bench for sd_frame_ctrl: default build, a 2-bit counter build and a
// single-word 0001-pattern build share one stimulus stream.
module tb_sd_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start_c = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  logic       in_ready_a, busy_a, sd_din_a, sd_bit_valid_a, hit_a, done_a, overflow_a;
  logic [7:0] match_cnt_a;
  logic       in_ready_b, busy_b, sd_din_b, sd_bit_valid_b, hit_b, done_b, overflow_b;
  logic [1:0] match_cnt_b;
  logic       in_ready_c, busy_c, sd_din_c, sd_bit_valid_c, hit_c, done_c, overflow_c;
  logic [7:0] match_cnt_c;

  sd_frame_ctrl u_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .busy(busy_a), .sd_din(sd_din_a), .sd_bit_valid(sd_bit_valid_a),
    .hit(hit_a), .match_cnt(match_cnt_a), .done(done_a), .overflow(overflow_a));

  sd_frame_ctrl #(.CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .busy(busy_b), .sd_din(sd_din_b), .sd_bit_valid(sd_bit_valid_b),
    .hit(hit_b), .match_cnt(match_cnt_b), .done(done_b), .overflow(overflow_b));

  sd_frame_ctrl #(.PATTERN(4'b0001), .FRAME_LEN(1)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_c), .busy(busy_c), .sd_din(sd_din_c), .sd_bit_valid(sd_bit_valid_c),
    .hit(hit_c), .match_cnt(match_cnt_c), .done(done_c), .overflow(overflow_c));

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] hits_a;
    int          cnt_a;
    int          ovf_a;
    int          cnt_b;
    int          ovf_b;
    logic [7:0]  hits_c;
    int          cnt_c;
    bit          glitch;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail = 0;
  int   prev_cnt_a, prev_ovf_a, prev_cnt_b, prev_ovf_b;
  int   widx, got, acc;
  int   e_busy, e_rdy, e_bv, e_din, e_hit, e_hit_c;
  logic [7:0] w0, w1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{8'h1B, 8'h40, 16'h0240, 2, 0, 2, 0, 8'h08, 1, 1'b0};
    vecs[1] = '{8'hDB, 8'h6D, 16'h9248, 5, 0, 3, 1, 8'h00, 0, 1'b1};
    vecs[2] = '{8'h80, 8'h10, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 1'b0};
    vecs[3] = '{8'h10, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h08, 1, 1'b1};
    vecs[4] = '{8'h0D, 8'hD0, 16'h0880, 2, 0, 2, 0, 8'h10, 1, 1'b0};
    vecs[5] = '{8'h00, 8'h06, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 1'b0};
    vecs[6] = '{8'h80, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready_a, 0);
    check("rst busy", busy_a, 0);
    check("rst bit_valid", sd_bit_valid_a, 0);
    check("rst done", done_a, 0);
    check("rst match_cnt", match_cnt_a, 0);
    check("rst overflow", overflow_a, 0);
    reset = 1'b0;

    // Reset mid-SHIFT at bit 3 of a word
    @(negedge clk); start = 1'b1; start_c = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk); start = 1'b0; start_c = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst bit_valid", sd_bit_valid_a, 1);
    check("pre-rst sd_din", sd_din_a, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst in_ready", in_ready_a, 0);
    check("midrst busy", busy_a, 0);
    check("midrst sd_din", sd_din_a, 0);
    check("midrst bit_valid", sd_bit_valid_a, 0);
    check("midrst hit", hit_a, 0);
    check("midrst done", done_a, 0);
    check("midrst match_cnt", match_cnt_a, 0);
    check("midrst overflow", overflow_a, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("postrst in_ready c%0d", i), in_ready_a, 0);
      check($sformatf("postrst busy c%0d", i), busy_a, 0);
    end
    in_valid = 1'b0;

    // Stall in WAIT with in_valid low, then complete the frame
    @(negedge clk); start = 1'b1; start_c = 1'b1; in_data = 8'h1B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b0; start_c = 1'b0;
      check($sformatf("stall busy c%0d", i), busy_a, 1);
      check($sformatf("stall in_ready c%0d", i), in_ready_a, 1);
      check($sformatf("stall bit_valid c%0d", i), sd_bit_valid_a, 0);
    end
    in_valid = 1'b1;
    got = 0; acc = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      in_data = (acc != 0) ? 8'h40 : 8'h1B;
      if (in_ready_a) acc = 1;
      @(negedge clk);
      if (done_a) got = 1;
    end
    check("stall done seen", got, 1);
    check("stall match_cnt", match_cnt_a, 2);
    check("stall overflow", overflow_a, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    prev_cnt_a = 2; prev_ovf_a = 0; prev_cnt_b = 2; prev_ovf_b = 0;

    // Table-driven frames with in_valid held high from the start cycle
    for (int v = 0; v < 7; v++) begin
      w0 = vecs[v].w0; w1 = vecs[v].w1; widx = 0;
      for (int t = 0; t <= 21; t++) begin
        @(negedge clk);
        e_busy = (t >= 1 && t <= 19) ? 1 : 0;
        e_rdy  = (t == 1 || t == 10) ? 1 : 0;
        e_bv   = ((t >= 2 && t <= 9) || (t >= 11 && t <= 18)) ? 1 : 0;
        e_din  = 0; e_hit = 0; e_hit_c = 0;
        if (t >= 2 && t <= 9) begin
          e_din = w0[9-t]; e_hit = vecs[v].hits_a[t-2]; e_hit_c = vecs[v].hits_c[t-2];
        end else if (t >= 11 && t <= 18) begin
          e_din = w1[18-t]; e_hit = vecs[v].hits_a[t-3];
        end
        check($sformatf("v%0d t%0d busy", v, t), busy_a, e_busy);
        check($sformatf("v%0d t%0d in_ready", v, t), in_ready_a, e_rdy);
        check($sformatf("v%0d t%0d bit_valid", v, t), sd_bit_valid_a, e_bv);
        check($sformatf("v%0d t%0d sd_din", v, t), sd_din_a, e_din);
        check($sformatf("v%0d t%0d hit", v, t), hit_a, e_hit);
        check($sformatf("v%0d t%0d done", v, t), done_a, (t == 19) ? 1 : 0);
        check($sformatf("v%0d t%0d done_b", v, t), done_b, (t == 19) ? 1 : 0);
        check($sformatf("v%0d t%0d busy_c", v, t), busy_c, (t >= 1 && t <= 10) ? 1 : 0);
        check($sformatf("v%0d t%0d hit_c", v, t), hit_c, e_hit_c);
        check($sformatf("v%0d t%0d done_c", v, t), done_c, (t == 10) ? 1 : 0);
        if (t == 0) begin
          check($sformatf("v%0d hold cnt_a", v), match_cnt_a, prev_cnt_a);
          check($sformatf("v%0d hold ovf_a", v), overflow_a, prev_ovf_a);
          check($sformatf("v%0d hold cnt_b", v), match_cnt_b, prev_cnt_b);
          check($sformatf("v%0d hold ovf_b", v), overflow_b, prev_ovf_b);
        end
        if (t == 1) begin
          check($sformatf("v%0d clr cnt_a", v), match_cnt_a, 0);
          check($sformatf("v%0d clr cnt_b", v), match_cnt_b, 0);
          check($sformatf("v%0d clr ovf_b", v), overflow_b, 0);
          check($sformatf("v%0d clr cnt_c", v), match_cnt_c, 0);
        end
        if (t >= 19) begin
          check($sformatf("v%0d t%0d cnt_a", v, t), match_cnt_a, vecs[v].cnt_a);
          check($sformatf("v%0d t%0d ovf_a", v, t), overflow_a, vecs[v].ovf_a);
          check($sformatf("v%0d t%0d cnt_b", v, t), match_cnt_b, vecs[v].cnt_b);
          check($sformatf("v%0d t%0d ovf_b", v, t), overflow_b, vecs[v].ovf_b);
        end
        if (t >= 10) begin
          check($sformatf("v%0d t%0d cnt_c", v, t), match_cnt_c, vecs[v].cnt_c);
          check($sformatf("v%0d t%0d ovf_c", v, t), overflow_c, 0);
        end
        start    = (t == 0) || (vecs[v].glitch && (t == 5 || t == 19));
        start_c  = (t == 0) || (vecs[v].glitch && t == 5);
        in_valid = 1'b1;
        in_data  = (widx == 0) ? w0 : w1;
        if (in_ready_a) widx = 1;
      end
      start = 1'b0; start_c = 1'b0; in_valid = 1'b0;
      prev_cnt_a = vecs[v].cnt_a; prev_ovf_a = vecs[v].ovf_a;
      prev_cnt_b = vecs[v].cnt_b; prev_ovf_b = vecs[v].ovf_b;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_frame_ctrl.md
Name: sd_frame_ctrl

Overview:
Frame-level controller for the serial pattern detector path. It accepts bytes over a valid/ready handshake and serialises them MSB-first, one bit per cycle. It runs an overlapping pattern match on the serial stream, counts the matches in a frame of FRAME_LEN bytes, and reports the count with a one-cycle done pulse. It sits between a byte-wide producer and status/readout logic, and replaces hand-driven din sequencing.

Parameters:
DATA_W, 8, bits per input word
PAT_W, 4, pattern length in bits
PATTERN, 4'b1101, pattern to detect; first-received bit is the MSB
FRAME_LEN, 2, words per frame (>=1)
CNT_W, 8, width of match counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin a frame; honoured only in IDLE
in_valid  input  1  producer has a word
in_data  input  DATA_W  word to serialise
in_ready  output  1  controller can accept a word
busy  output  1  high in any state other than IDLE
sd_din  output  1  current serial bit (MSB-first)
sd_bit_valid  output  1  sd_din is valid this cycle
hit  output  1  pattern completes on the current bit (combinational, qualified by sd_bit_valid)
match_cnt  output  CNT_W  matches in current/last frame
done  output  1  one-cycle pulse at end of frame
overflow  output  1  sticky: match_cnt saturated this frame

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values:
  - state=IDLE.
  - in_ready, busy, sd_din, sd_bit_valid, hit, done, overflow = 0.
  - match_cnt = 0.
  - Internal history, bit index and word count all cleared.
- State machine (IDLE, WAIT, SHIFT, DONE):
  - IDLE: if start, go to WAIT. On that edge clear match_cnt, overflow, the history register, the fill count and the word count.
  - WAIT: in_ready=1. On in_valid&&in_ready, latch in_data into the shift register and go to SHIFT. If in_valid stays low, stall indefinitely with no timeout.
  - SHIFT: in_ready=0, sd_bit_valid=1, sd_din = shreg[DATA_W-1]. Shift left each cycle for DATA_W cycles. After the last bit, increment the word count. If the count equals FRAME_LEN, go to DONE; otherwise go to WAIT.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored, including start in the DONE cycle.
- Detection (overlapping, spans word boundaries within a frame, never across frames):
  - hist holds the last PAT_W-1 bits.
  - hit = sd_bit_valid && {hist,sd_din}==PATTERN && fill>=PAT_W-1.
  - fill counts bits seen this frame and saturates at PAT_W-1. The fill check prevents false hits against cleared history, e.g. for patterns with leading zeros.
  - hist updates with sd_din on every valid bit.
- Counting:
  - On each hit edge, if match_cnt < 2^CNT_W-1, increment it; otherwise hold and set overflow.
  - match_cnt and overflow hold after DONE until the next accepted start.
- Latency: with in_valid held high, the start cycle is t0. Words are accepted at t0+1, t0+1+(DATA_W+1), and so on. done is asserted at t0+1+FRAME_LEN*(DATA_W+1). Defaults give 19.
- Reset mid-frame, in any state: immediate return to reset values. Any partial frame is discarded.
- Simultaneous start and in_valid in IDLE: only start acts. in_ready is 0 in IDLE, so no word is accepted.

Test Plan:
- Reset mid-SHIFT (assert reset at bit 3 of a word): all outputs 0 the same cycle; after release, in_ready=0 until a start.
- Cross-word match, defaults, words 0x1B then 0x40, in_valid held high:
  - hit at frame bits 7 and 10;
  - done at t0+19 with match_cnt=2 and overflow=0;
  - in_ready high exactly at t0+1 and t0+10.
- Overlap, words 0xDB, 0x6D (stream 1101101101101101): 5 hits at bits 4, 7, 10, 13, 16; match_cnt=5.
- Saturation, CNT_W=2, words 0xDB, 0x6D: match_cnt=3, overflow=1, held after done; the next start clears both.
- Fill qualification, PATTERN=4'b0001, FRAME_LEN=1, word 0x80: no hit on bit 1; match_cnt=0. Word 0x10 gives exactly one hit, at bit 4.
- Stall and ignored start:
  - in_valid low for 5 cycles in WAIT: busy=1, no sd_bit_valid, then the frame resumes correctly.
  - start pulsed during SHIFT and during DONE has no effect; the controller returns to IDLE after done.
